// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, complex sample type and bit-reversal helper for the FFT front end.
package fft_pkg;
  localparam int DW = 16;
  localparam int N = 16;
  localparam int LOG2N = 4;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;
  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] i);
    return {i[0], i[1], i[2], i[3]};
  endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: 16-entry complex register bank with per-slot write enables and a bulk load port.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     we,
  input  cplx_t            wdata,
  input  logic             load,
  input  cplx_t [N-1:0]    ldata,
  output cplx_t [N-1:0]    q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (load) q <= ldata;
    else for (int i = 0; i < N; i++) if (we[i]) q[i] <= wdata;
endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: double-buffered serial-to-parallel loader for the 16-point FFT.
// FFT_IN_BITREV_EN selects bit-reversed slot placement; otherwise samples land in natural order.
module fft_input_loader
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_real,
  input  logic [DW-1:0]   in_im,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic [N*DW-1:0] frame_real,
  output logic [N*DW-1:0] frame_im
);
  logic [LOG2N-1:0] cnt, slot;
  logic fill_full, hold_full, accept, xfer;
  logic [N-1:0] we;
  cplx_t sample;
  cplx_t [N-1:0] fill_q, hold_q;
  assign in_ready = !fill_full;
  assign frame_valid = hold_full;
  assign accept = in_valid && in_ready;
  // hold may be refilled on the same edge downstream takes it, so back-to-back frames have no bubble
  assign xfer = fill_full && (!hold_full || frame_ready);
`ifdef FFT_IN_BITREV_EN
  assign slot = bitrev4(cnt);
`else
  assign slot = cnt;
`endif
  assign we = accept ? N'(1) << slot : '0;
  assign sample = {in_real, in_im};
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      fill_full <= 1'b0;
      hold_full <= 1'b0;
    end else begin
      if (accept) cnt <= cnt + 1'b1;
      fill_full <= (accept && cnt == LOG2N'(N - 1)) ? 1'b1 : xfer ? 1'b0 : fill_full;
      hold_full <= xfer ? 1'b1 : frame_ready ? 1'b0 : hold_full;
    end
  fft_frame_bank u_fill (
    .clk(clk), .rst_n(rst_n), .we(we), .wdata(sample),
    .load(1'b0), .ldata('0), .q(fill_q)
  );
  fft_frame_bank u_hold (
    .clk(clk), .rst_n(rst_n), .we('0), .wdata('0),
    .load(xfer), .ldata(fill_q), .q(hold_q)
  );
  for (genvar k = 0; k < N; k++) begin : g_out
    assign frame_real[k*DW +: DW] = hold_q[k].re;
    assign frame_im[k*DW +: DW] = hold_q[k].im;
  end
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: directed and randomized checks of the loader against a frame-level queue model.
module tb_fft_input_loader;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, frame_valid, frame_ready;
  logic [15:0] in_real, in_im;
  logic [255:0] frame_real, frame_im;
  int total = 0, bad = 0, low_cnt = 0, pulses = 0;
  logic [15:0] fq_re[$], fq_im[$];
  logic [15:0] done_re[16], done_im[16], hold_re[16], hold_im[16];
  bit done_v = 0, hold_v = 0;
  logic [15:0] cur_re, cur_im;
`ifdef FFT_IN_BITREV_EN
  localparam int S1 = 8, S3 = 12;
`else
  localparam int S1 = 1, S3 = 3;
`endif

  always #5 clk = ~clk;

  fft_input_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_im(in_im), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_real(frame_real), .frame_im(frame_im)
  );

  function automatic int slot_of(int n);
`ifdef FFT_IN_BITREV_EN
    int r = 0;
    for (int b = 0; b < 4; b++) if (n[b]) r = r | (8 >> b);
    return r;
`else
    return n;
`endif
  endfunction

  function automatic logic [255:0] pack(input logic [15:0] a[16]);
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[k*16 +: 16] = a[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [15:0] re, input logic [15:0] im,
                      input bit fr, input bit rn, output bit acc);
    bit xfer;
    in_valid = v; in_real = re; in_im = im; frame_ready = fr; rst_n = rn;
    if (in_ready === 1'b0) low_cnt++;
    if (frame_valid === 1'b1 && fr) pulses++;
    acc = rn && v && !done_v;
    xfer = rn && done_v && (!hold_v || fr);
    @(posedge clk);
    if (!rn) begin
      fq_re.delete(); fq_im.delete();
      done_v = 0; hold_v = 0;
      foreach (hold_re[i]) begin hold_re[i] = '0; hold_im[i] = '0; end
    end else begin
      if (xfer) begin
        hold_re = done_re; hold_im = done_im; hold_v = 1; done_v = 0;
      end else if (fr) hold_v = 0;
      if (acc) begin
        fq_re.push_back(re); fq_im.push_back(im);
        if (fq_re.size() == 16) begin
          for (int n = 0; n < 16; n++) begin
            done_re[slot_of(n)] = fq_re[n];
            done_im[slot_of(n)] = fq_im[n];
          end
          done_v = 1;
          fq_re.delete(); fq_im.delete();
        end
      end
    end
    #1;
    chk("in_ready", in_ready, !done_v);
    chk("frame_valid", frame_valid, hold_v);
    chk("frame_real", frame_real, pack(hold_re));
    chk("frame_im", frame_im, pack(hold_im));
  endtask

  initial begin
    bit a;
    int cnt_acc, sent;
    step(0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, a);
    for (int i = 0; i < 16; i++) step(1, 16'(i), 16'(-i), 1, 1, a);
    step(0, 0, 0, 0, 1, a);
    chk("first_valid", frame_valid, 1);
    chk("slot15_re", frame_real[15*16 +: 16], 16'd15);
    chk("slot_n1_re", frame_real[S1*16 +: 16], 16'd1);
    chk("slot_n1_im", frame_im[S1*16 +: 16], 16'hFFFF);
    chk("slot_n3_re", frame_real[S3*16 +: 16], 16'd3);
    // backpressure: frame 0 held, frame 1 fills, then the loader stalls
    cnt_acc = 0;
    cur_re = 16'($urandom); cur_im = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      step(1, cur_re, cur_im, 0, 1, a);
      if (a) begin cnt_acc++; cur_re = 16'($urandom); cur_im = 16'($urandom); end
    end
    chk("stall_accepts", 32'(cnt_acc), 32'd16);
    chk("stall_ready", in_ready, 0);
    step(1, cur_re, cur_im, 1, 1, a);
    if (a) begin cur_re = 16'($urandom); cur_im = 16'($urandom); end
    chk("release_valid", frame_valid, 1);
    chk("release_ready", in_ready, 1);
    // continuous streaming of three frames
    step(0, 0, 0, 0, 0, a);
    low_cnt = 0; pulses = 0;
    for (int i = 0; i < 52; i++) begin
      step(1, cur_re, cur_im, 1, 1, a);
      if (a) begin cur_re = 16'($urandom); cur_im = 16'($urandom); end
    end
    chk("stream_low_cycles", 32'(low_cnt), 32'd3);
    chk("stream_pulses", 32'(pulses), 32'd3);
    // reset mid-frame discards the partial frame
    step(0, 0, 0, 0, 0, a);
    for (int i = 0; i < 7; i++) step(1, 16'($urandom), 16'($urandom), 0, 1, a);
    step(0, 0, 0, 0, 0, a);
    for (int i = 0; i < 16; i++) step(1, 16'(100 + i), 16'(i), 0, 1, a);
    step(0, 0, 0, 0, 1, a);
    chk("reset_slot0", frame_real[15:0], 16'd100);
    // sparse in_valid with extreme values
    step(0, 0, 0, 0, 0, a);
    sent = 0;
    for (int i = 0; i < 300 && sent < 16; i++) begin
      step(1'($urandom % 2), sent[0] ? 16'h8000 : 16'h7FFF, sent[0] ? 16'h7FFF : 16'h8000, 1, 1, a);
      if (a) sent++;
    end
    chk("sparse_sent", 32'(sent), 32'd16);
    step(0, 0, 0, 0, 1, a);
    step(0, 0, 0, 0, 1, a);
    chk("sparse_slot0", frame_real[15:0], 16'h7FFF);
    chk("sparse_slot15", frame_im[15*16 +: 16], 16'h7FFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
